// File: rtl/cla9_seq.sv
// Sequential W-bit add/subtract that pushes 9-bit chunks LSB-first through
// a single shared 9-bit carry-lookahead adder, one chunk per clock.
//
// state | meaning
// IDLE  | waiting for start; s/cout/ovf hold the last result
// RUN   | adding chunk idx, carry passed to the next chunk via the carry register
// DONE  | result complete; pulse done and return to IDLE
module cla9_seq #(
  parameter int NCHUNK = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [9*NCHUNK-1:0]   a,
  input  logic [9*NCHUNK-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [9*NCHUNK-1:0]   s,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W = 9 * NCHUNK;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [W-1:0]   a_r;
  logic [W-1:0]   b_r;
  logic           carry;
  logic [2:0]     idx;

  logic [8:0]     ca;
  logic [8:0]     cb;
  logic [8:0]     g;
  logic [8:0]     p;
  logic [9:0]     c;
  logic [8:0]     sum9;
  logic           co;

  assign ca = a_r[9*idx +: 9];
  assign cb = b_r[9*idx +: 9];
  assign g  = ca & cb;
  assign p  = ca ^ cb;

  // Each carry is a flat sum-of-products of generate/propagate terms, so no
  // carry depends on a previously computed carry.
  always_comb begin
    logic cc;
    logic pr;
    c  = '0;
    cc = 1'b0;
    pr = 1'b0;
    c[0] = carry;
    for (int i = 0; i < 9; i++) begin
      cc = g[i];
      pr = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        cc = cc | (pr & g[j]);
        pr = pr & p[j];
      end
      c[i+1] = cc | (pr & carry);
    end
  end

  assign sum9 = p ^ c[8:0];
  assign co   = c[9];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_r   <= '0;
      b_r   <= '0;
      carry <= 1'b0;
      idx   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      s     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b ^ {W{sub}};
            carry <= sub;
            idx   <= '0;
            s     <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          s[9*idx +: 9] <= sum9;
          carry         <= co;
          if (idx == 3'(NCHUNK - 1)) begin
            cout  <= co;
            ovf   <= (a_r[W-1] == b_r[W-1]) && (sum9[8] != a_r[W-1]);
            state <= DONE;
          end else begin
            idx <= idx + 3'd1;
          end
        end
        DONE: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          idx   <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cla9_seq.sv
// Directed bench for cla9_seq (NCHUNK=4): arithmetic corners, latency,
// start-while-busy rejection and asynchronous reset abort.
module tb_cla9_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [35:0] a;
  logic [35:0] b;
  logic        busy;
  logic        done;
  logic [35:0] s;
  logic        cout;
  logic        ovf;

  int tests = 0;
  int fails = 0;

  cla9_seq #(.NCHUNK(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .s     (s),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, scramble the inputs right after acceptance, then
  // check latency, result, flags and that done lasts a single cycle.
  task automatic run_op(input string tag, input logic sb, input logic [35:0] av,
                        input logic [35:0] bv, input logic [35:0] es,
                        input logic ec, input logic eo);
    int cnt;
    @(negedge clk);
    start = 1'b1; sub = sb; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; sub = ~sb; a = ~av; b = bv ^ 36'h5_A5A5_A5A5;
    chk({tag, "_busy"}, busy, 1);
    cnt = 0;
    while (done !== 1'b1 && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 5);
    chk({tag, "_s"}, s, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 0);
  endtask

  initial begin
    int cnt;
    int ndone;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
    #23;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_s", s, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_1ff", 1'b0, 36'h0_0000_01FF, 36'h1, 36'h0_0000_0200, 1'b0, 1'b0);
    run_op("add_wrap", 1'b0, 36'hF_FFFF_FFFF, 36'h1, 36'h0, 1'b1, 1'b0);
    run_op("sub_5_7", 1'b1, 36'h5, 36'h7, 36'hF_FFFF_FFFE, 1'b0, 1'b0);
    run_op("sub_7_5", 1'b1, 36'h7, 36'h5, 36'h2, 1'b1, 1'b0);
    run_op("add_ovf", 1'b0, 36'h7_FFFF_FFFF, 36'h1, 36'h8_0000_0000, 1'b0, 1'b1);
    run_op("sub_ovf", 1'b1, 36'h8_0000_0000, 36'h1, 36'h7_FFFF_FFFF, 1'b1, 1'b1);
    run_op("add_mix", 1'b0, 36'h1_2345_6789, 36'h0_FEDC_BA98, 36'h2_2222_2221, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("idle_hold_s", s, 36'h2_2222_2221);
    chk("idle_hold_busy", busy, 0);

    // Second start during RUN must be dropped.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 36'h100; b = 36'h23;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; sub = 1'b1; a = 36'hABC; b = 36'h111;
    @(posedge clk); #1;
    start = 1'b0;
    ndone = 0;
    cnt = 1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      cnt++;
      if (done === 1'b1) begin
        ndone++;
        chk("busy_drop_lat", cnt, 5);
        chk("busy_drop_s", s, 36'h123);
      end
    end
    chk("busy_drop_ndone", ndone, 1);

    // Reset while chunk 2 is being processed.
    @(negedge clk);
    start = 1'b1; sub = 1'b0; a = 36'h1; b = 36'h2;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_s", s, 36'h3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s", s, 0);
    chk("mid_rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) ndone++;
    end
    chk("post_rst_no_done", ndone, 0);

    run_op("after_rst", 1'b1, 36'h0_0000_1000, 36'h0_0000_0001, 36'h0_0000_0FFF, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
